// File: rtl/if_stage.sv
// if_stage: instruction fetch with single-outstanding imem handshake,
// stall hold buffer and jump squash, feeding a registered word to decode.
module if_stage #(
  parameter int ARQ    = 16,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_en,
  input  logic              jenable,
  input  logic [ADDR_W-1:0] jaddr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [ARQ-1:0]    imem_rdata,
  input  logic              imem_ack,
  output logic [ARQ-1:0]    instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out
);

  typedef enum logic [1:0] {IDLE, FETCH, SQUASH, HOLD} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc, addr_n, pc_out_n, hold_addr, hold_addr_n;
  logic [ARQ-1:0]    instr_n, hold_data, hold_data_n;
  logic              req_n, valid_n;

  assign pc_inc = pc + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc_out      <= '0;
      hold_data   <= '0;
      hold_addr   <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      imem_req    <= req_n;
      imem_addr   <= addr_n;
      instr       <= instr_n;
      instr_valid <= valid_n;
      pc_out      <= pc_out_n;
      hold_data   <= hold_data_n;
      hold_addr   <= hold_addr_n;
    end
  end

  // In FETCH pc always equals imem_addr; in SQUASH pc is the pending jump target.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    req_n       = imem_req;
    addr_n      = imem_addr;
    instr_n     = instr;
    valid_n     = instr_valid;
    pc_out_n    = pc_out;
    hold_data_n = hold_data;
    hold_addr_n = hold_addr;
    case (state)
      IDLE: begin
        state_n = FETCH;
        req_n   = 1'b1;
        pc_n    = jenable ? jaddr : pc;
        addr_n  = jenable ? jaddr : pc;
      end
      FETCH: begin
        if (jenable) begin
          pc_n    = jaddr;
          instr_n = '0;
          valid_n = 1'b0;
          addr_n  = imem_ack ? jaddr : imem_addr;
          state_n = imem_ack ? FETCH : SQUASH;
        end else if (imem_ack && pc_en) begin
          instr_n  = imem_rdata;
          pc_out_n = imem_addr;
          valid_n  = 1'b1;
          pc_n     = pc_inc;
          addr_n   = pc_inc;
        end else if (imem_ack) begin
          hold_data_n = imem_rdata;
          hold_addr_n = imem_addr;
          req_n       = 1'b0;
          state_n     = HOLD;
        end else if (pc_en) begin
          valid_n = 1'b0;
        end
      end
      SQUASH: begin
        if (jenable) begin
          pc_n    = jaddr;
          instr_n = '0;
          valid_n = 1'b0;
        end
        if (imem_ack) begin
          addr_n  = jenable ? jaddr : pc;
          state_n = FETCH;
        end
      end
      HOLD: begin
        if (jenable) begin
          pc_n        = jaddr;
          instr_n     = '0;
          valid_n     = 1'b0;
          hold_data_n = '0;
          hold_addr_n = '0;
          req_n       = 1'b1;
          addr_n      = jaddr;
          state_n     = FETCH;
        end else if (pc_en) begin
          instr_n  = hold_data;
          valid_n  = 1'b1;
          pc_out_n = hold_addr;
          pc_n     = pc_inc;
          req_n    = 1'b1;
          addr_n   = pc_inc;
          state_n  = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 16-bit pipeline, directly upstream of the decode stage. It owns the program counter and issues one-outstanding-request fetches to instruction memory over a req/ack handshake. It presents a registered instruction plus a valid flag to decode, and honours the stall (pc_en) and jump redirect (jenable, 13-bit jump address) produced by decode's control unit, squashing in-flight fetches on a jump.

Parameters:
ARQ, 16, instruction/data word width
ADDR_W, 13, instruction address width (matches jump address field)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
pc_en  in  1  1 = pipeline advances; 0 = stall, hold IF/ID outputs
jenable  in  1  jump redirect request from decode
jaddr  in  ADDR_W  jump target
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address, stable while imem_req=1
imem_rdata  in  ARQ  instruction word, valid when imem_ack=1
imem_ack  in  1  one-cycle completion of the outstanding request
instr  out  ARQ  registered instruction to decode
instr_valid  out  1  instr holds a real instruction (0 = bubble)
pc_out  out  ADDR_W  address of the word currently in instr

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=0, imem_req=0, imem_addr=0, instr=0, instr_valid=0, pc_out=0, hold buffer cleared.
- States: IDLE, FETCH, SQUASH, HOLD. All outputs registered.
- IDLE: one cycle after reset release -> FETCH with imem_req=1, imem_addr=pc.
- Handshake: at most one request outstanding; imem_req and imem_addr stay constant from assertion until the ack cycle. A new request (next address) may be issued in the cycle after ack. Back-to-back ack gives one instruction every cycle.
- Priority in every state: jenable > imem_ack > pc_en.
- FETCH, jenable=1:
  - pc<=jaddr, instr<=0, instr_valid<=0.
  - If imem_ack in the same cycle: discard data, stay FETCH, next request to jaddr.
  - Else -> SQUASH; old request stays asserted.
- FETCH, ack, pc_en=1: instr<=imem_rdata, pc_out<=imem_addr, instr_valid<=1, pc<=pc+1, next request at pc+1.
- FETCH, ack, pc_en=0: capture word and address into the hold buffer, instr/instr_valid/pc_out unchanged, imem_req<=0 -> HOLD.
- FETCH, no ack, pc_en=1: instr_valid<=0 (bubble). With pc_en=0 the outputs hold.
- SQUASH: keeps the old request until ack. Data on ack is discarded, then -> FETCH at pc (the jump target). jenable again in SQUASH overwrites pc with the new jaddr.
- HOLD: no request.
  - pc_en=1: instr<=buffer, instr_valid<=1, pc_out<=buffered address, pc<=pc+1 -> FETCH.
  - jenable: drop buffer, pc<=jaddr, instr<=0, instr_valid<=0 -> FETCH.
- PC arithmetic: unsigned ADDR_W bits, pc+1 wraps 2^ADDR_W-1 -> 0.
- jenable while pc_en=0: the jump is still taken; outputs are cleared to a bubble.
- Reset mid-request: request dropped immediately. A late imem_ack after reset is ignored because state is IDLE.

Test Plan:
- Reset then a memory acking every cycle with rdata=0x1000+addr -> imem_addr 0,1,2,...; instr 0x1000,0x1001,... one per cycle; instr_valid=1 from the 3rd cycle after reset release.
- Ack latency 3 cycles, pc_en=1 -> imem_req/imem_addr stable for 3 cycles; instr_valid=0 bubbles between words; no address skipped.
- Stall: pc_en=0 for 4 cycles during an ack of addr 5 -> instr keeps the addr-4 word; on pc_en=1 the addr-5 word appears with pc_out=5, followed by a fetch of addr 6.
- Jump during an outstanding fetch: jenable with jaddr=0x0100 while the request to addr 7 is pending, ack 2 cycles later -> addr-7 data discarded, instr_valid=0, next imem_addr=0x0100, instr shows the 0x0100 word.
- Same-cycle jenable and ack -> acked data dropped, next request at jaddr; jenable with pc_en=0 in HOLD -> buffer dropped, fetch jaddr.
- Wrap: start pc at 0x1FFF via jump -> next fetch address 0x0000. Assert rst mid-request -> all outputs 0 asynchronously; a stray ack is ignored.
